// File: rtl/mc_ctrl.sv
// Multicycle MIPS main control: state register plus per-state datapath control decode.
// Optional feature: define MC_CTRL_ADDIU_EN to decode addiu (001001); otherwise it is illegal.
module mc_ctrl (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] op,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       PCWr,
    output logic       IorD,
    output logic       MemRd,
    output logic       MemWr,
    output logic       IRWr,
    output logic       RegDst,
    output logic       MemtoReg,
    output logic       RegWr,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic       ExtOp,
    output logic [1:0] AluOp,
    output logic [1:0] PCSrc,
    output logic       illegal,
    output logic [3:0] state
);

    localparam int unsigned OP_W = 6;
    localparam int unsigned ST_W = 4;

    localparam logic [OP_W-1:0] OP_R     = 6'b000000;
    localparam logic [OP_W-1:0] OP_LW    = 6'b100011;
    localparam logic [OP_W-1:0] OP_SW    = 6'b101011;
    localparam logic [OP_W-1:0] OP_BEQ   = 6'b000100;
    localparam logic [OP_W-1:0] OP_J     = 6'b000010;
    localparam logic [OP_W-1:0] OP_ORI   = 6'b001101;
`ifdef MC_CTRL_ADDIU_EN
    localparam logic [OP_W-1:0] OP_ADDIU = 6'b001001;
`endif

    typedef enum logic [ST_W-1:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_RWB    = 4'd7,
        S_BRANCH = 4'd8,
        S_JUMP   = 4'd9,
        S_IEXEC  = 4'd10,
        S_IWB    = 4'd11
    } state_e;

    state_e state_q, state_d;
    logic   illegal_q, illegal_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_FETCH;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            illegal_q <= illegal_d;
        end
    end

    // Next-state sequencing; illegal is flagged for the FETCH following DECODE.
    always_comb begin
        state_d   = S_FETCH;
        illegal_d = 1'b0;
        case (state_q)
            S_FETCH:  state_d = mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (op)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_R:         state_d = S_EXEC;
                    OP_BEQ:       state_d = S_BRANCH;
                    OP_J:         state_d = S_JUMP;
                    OP_ORI:       state_d = S_IEXEC;
`ifdef MC_CTRL_ADDIU_EN
                    OP_ADDIU:     state_d = S_IEXEC;
`endif
                    default:      illegal_d = 1'b1;
                endcase
            end
            S_MEMADR: state_d = (op == OP_SW) ? S_MEMWR : S_MEMRD;
            S_MEMRD:  state_d = mem_ready ? S_MEMWB : S_MEMRD;
            S_MEMWR:  state_d = mem_ready ? S_FETCH : S_MEMWR;
            S_EXEC:   state_d = S_RWB;
            S_BRANCH,
            S_JUMP,
            S_MEMWB,
            S_RWB,
            S_IWB:    state_d = S_FETCH;
            S_IEXEC:  state_d = S_IWB;
            default:  state_d = S_FETCH;
        endcase
    end

    // Control decode from the current state; everything held low during reset.
    always_comb begin
        PCWr     = 1'b0;
        IorD     = 1'b0;
        MemRd    = 1'b0;
        MemWr    = 1'b0;
        IRWr     = 1'b0;
        RegDst   = 1'b0;
        MemtoReg = 1'b0;
        RegWr    = 1'b0;
        ALUSrcA  = 1'b0;
        ALUSrcB  = 2'b00;
        ExtOp    = 1'b0;
        AluOp    = 2'b00;
        PCSrc    = 2'b00;
        if (rst_n) begin
            case (state_q)
                S_FETCH: begin
                    MemRd   = 1'b1;
                    ALUSrcB = 2'b01;
                    IRWr    = mem_ready;
                    PCWr    = mem_ready;
                end
                S_DECODE: begin
                    ALUSrcB = 2'b11;
                    ExtOp   = 1'b1;
                end
                S_MEMADR: begin
                    ALUSrcA = 1'b1;
                    ALUSrcB = 2'b10;
                    ExtOp   = 1'b1;
                end
                S_MEMRD: begin
                    MemRd = 1'b1;
                    IorD  = 1'b1;
                end
                S_MEMWB: begin
                    RegWr    = 1'b1;
                    MemtoReg = 1'b1;
                end
                S_MEMWR: begin
                    MemWr = 1'b1;
                    IorD  = 1'b1;
                end
                S_EXEC: begin
                    ALUSrcA = 1'b1;
                    AluOp   = 2'b11;
                end
                S_RWB: begin
                    RegWr  = 1'b1;
                    RegDst = 1'b1;
                end
                S_BRANCH: begin
                    ALUSrcA = 1'b1;
                    AluOp   = 2'b01;
                    PCSrc   = 2'b01;
                    PCWr    = zero;
                end
                S_JUMP: begin
                    PCSrc = 2'b10;
                    PCWr  = 1'b1;
                end
                S_IEXEC: begin
                    ALUSrcA = 1'b1;
                    ALUSrcB = 2'b10;
                    AluOp   = 2'b10;
`ifdef MC_CTRL_ADDIU_EN
                    if (op == OP_ADDIU) begin
                        AluOp = 2'b00;
                        ExtOp = 1'b1;
                    end
`endif
                end
                S_IWB: RegWr = 1'b1;
                default: ;
            endcase
        end
    end

    assign illegal = illegal_q;
    assign state   = state_q;

endmodule
